// File: rtl/filter_peak_detector.sv
// Pulse peak detector on the shaped sample stream: peak amplitude, peak time and width per pulse.
// Optional FPD_STATS_EN adds saturating event_count / drop_count outputs.
module filter_peak_detector #(
    parameter int DATA_W    = 16,
    parameter int TS_W      = 32,
    parameter int WIDTH_W   = 8,
    parameter int MIN_WIDTH = 2,
    parameter int HOLDOFF   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] filter_data,
    input  logic signed [DATA_W-1:0] threshold,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] peak_amp,
    output logic [TS_W-1:0]          peak_time,
    output logic [WIDTH_W-1:0]       peak_width,
    output logic                     dropped
`ifdef FPD_STATS_EN
    ,
    output logic [15:0]              event_count,
    output logic [15:0]              drop_count
`endif
);

    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;
    localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_WIDTH);

    typedef enum logic [1:0] {IDLE, ABOVE, HOLD} state_t;

    state_t                     state, state_next;
    logic [TS_W-1:0]            timestamp;
    logic signed [DATA_W-1:0]   max_amp, max_next;
    logic [TS_W-1:0]            max_time, time_next;
    logic [WIDTH_W-1:0]         width_cnt, width_next;
    logic [HOLD_W-1:0]          hold_cnt, hold_next;
    logic                       above;
    logic                       accept;

    function automatic logic [WIDTH_W-1:0] sat_inc_width(input logic [WIDTH_W-1:0] v);
        return (v == WIDTH_MAX) ? v : v + WIDTH_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign above = filter_data > threshold;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            timestamp <= '0;
            max_amp   <= '0;
            max_time  <= '0;
            width_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            timestamp <= timestamp + TS_W'(1);
            max_amp   <= max_next;
            max_time  <= time_next;
            width_cnt <= width_next;
            hold_cnt  <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        max_next   = max_amp;
        time_next  = max_time;
        width_next = width_cnt;
        hold_next  = hold_cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (above) begin
                    state_next = ABOVE;
                    max_next   = filter_data;
                    time_next  = timestamp;
                    width_next = WIDTH_W'(1);
                end
            end
            ABOVE: begin
                if (above) begin
                    width_next = sat_inc_width(width_cnt);
                    // strict > keeps the earliest timestamp on ties
                    if (filter_data > max_amp) begin
                        max_next  = filter_data;
                        time_next = timestamp;
                    end
                end else begin
                    state_next = HOLD;
                    hold_next  = HOLD_LOAD;
                    accept     = (width_cnt >= MIN_W);
                end
            end
            HOLD: begin
                if (hold_cnt == '0) state_next = IDLE;
                else                hold_next  = hold_cnt - HOLD_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Event record register: a pending, unaccepted record wins over a new event
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            peak_amp   <= '0;
            peak_time  <= '0;
            peak_width <= '0;
            dropped    <= 1'b0;
        end else begin
            dropped <= 1'b0;
            if (accept && out_valid && !out_ready) begin
                dropped <= 1'b1;
            end else if (accept) begin
                out_valid  <= 1'b1;
                peak_amp   <= max_amp;
                peak_time  <= max_time;
                peak_width <= width_cnt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FPD_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            event_count <= '0;
            drop_count  <= '0;
        end else begin
            if (out_valid && out_ready)
                event_count <= sat_inc16(event_count);
            if (accept && out_valid && !out_ready)
                drop_count <= sat_inc16(drop_count);
        end
    end
`endif

endmodule

// File: tb/tb_filter_peak_detector.sv
// Directed bench for filter_peak_detector: pulse capture, rejection, holdoff, drops, signedness, saturation, reset.
// With FPD_STATS_EN defined the event/drop counters are also checked.
module tb_filter_peak_detector;

    localparam int DATA_W  = 16;
    localparam int TS_W    = 32;
    localparam int WIDTH_W = 8;
    localparam int HOLDOFF = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic signed [DATA_W-1:0] filter_data;
    logic signed [DATA_W-1:0] threshold;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] peak_amp;
    logic [TS_W-1:0]          peak_time;
    logic [WIDTH_W-1:0]       peak_width;
    logic                     dropped;
`ifdef FPD_STATS_EN
    logic [15:0]              event_count;
    logic [15:0]              drop_count;
`endif

    int      vectors = 0;
    int      miscompares = 0;
    longint  ts = 0;
    longint  t_mark;

    filter_peak_detector #(
        .DATA_W(DATA_W), .TS_W(TS_W), .WIDTH_W(WIDTH_W), .MIN_WIDTH(2), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .filter_data(filter_data),
        .threshold(threshold),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .peak_amp(peak_amp),
        .peak_time(peak_time),
        .peak_width(peak_width),
        .dropped(dropped)
`ifdef FPD_STATS_EN
        ,
        .event_count(event_count),
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one sample across one rising edge, outputs settle 1 time unit later
    task automatic send(input longint v);
        filter_data = DATA_W'(v);
        @(posedge clk);
        #1;
        if (reset) ts++;
    endtask

    task automatic idle(input int n, input longint v);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic check_record(input string tag, input longint amp, input longint tm, input longint w);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".amp"}, peak_amp, amp);
        check({tag, ".time"}, peak_time, tm);
        check({tag, ".width"}, peak_width, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        threshold   = 16'sd100;
        out_ready   = 1'b1;
        filter_data = 16'sd500;

        // Reset held three edges with an above-threshold input
        idle(3, 500);
        check("rst.valid", out_valid, 0);
        check("rst.amp", peak_amp, 0);
        check("rst.time", peak_time, 0);
        check("rst.width", peak_width, 0);
        check("rst.dropped", dropped, 0);
        reset = 1'b1;
        ts = 0;

        // Basic pulse: 50 120 300 300 150 80
        send(50); send(120); send(300); send(300); send(150);
        check("p1.pre_valid", out_valid, 0);
        send(80);
        check_record("p1", 300, 2, 4);
        check("p1.dropped", dropped, 0);
        send(50);
        check("p1.one_cycle", out_valid, 0);
        idle(HOLDOFF, 50);

        // Single-sample spike is rejected; holdoff ignores input for HOLDOFF+1 cycles
        send(50); send(200); send(50);
        check("spike.valid", out_valid, 0);
        check("spike.dropped", dropped, 0);
        idle(HOLDOFF + 1, 500);
        check("hold.valid", out_valid, 0);
        t_mark = ts;
        send(500); send(500); send(50);
        check_record("rearm", 500, t_mark, 2);
        send(50);
        idle(HOLDOFF, 50);

        // Back-to-back pulses with consumer stalled
        out_ready = 1'b0;
        t_mark = ts;
        send(400); send(450); send(50);
        check_record("bbA", 450, t_mark + 1, 2);
        idle(HOLDOFF + 1, 50);
        check_record("bbA.held", 450, t_mark + 1, 2);
        send(600); send(600); send(50);
        check("bbB.dropped", dropped, 1);
        check_record("bbB.kept", 450, t_mark + 1, 2);
        send(50);
        check("bbB.drop_once", dropped, 0);
        idle(HOLDOFF, 50);

        // Replacement when the old record transfers on the landing cycle
        t_mark = ts;
        send(700); send(700); send(700);
        out_ready = 1'b1;
        send(50);
        check_record("bbC", 700, t_mark, 3);
        check("bbC.dropped", dropped, 0);
        send(50);
        check("bbC.clear", out_valid, 0);
        idle(HOLDOFF, 50);

        // Negative threshold, signed comparison
        threshold = -16'sd200;
        send(-300);
        t_mark = ts;
        send(-100); send(-150); send(-300);
        check_record("neg", -100, t_mark, 2);
        send(-300);
        idle(HOLDOFF, -300);
        send(-200); send(-200); send(-200); send(-300);
        check("eq.valid", out_valid, 0);
        send(-300);
        check("eq.valid2", out_valid, 0);

        // Width saturation with tracking continuing past the saturation point
        threshold = 16'sd100;
        idle(280, 1000);
        t_mark = ts;
        send(2000);
        idle(20, 1000);
        send(50);
        check_record("sat", 2000, t_mark, 255);
        send(50);
        idle(HOLDOFF, 50);

        // Three accepted pulses with one drop
        out_ready = 1'b0;
        send(500); send(500); send(50);
        check("st1.valid", out_valid, 1);
        idle(HOLDOFF + 1, 50);
        send(500); send(500); send(50);
        check("st2.dropped", dropped, 1);
        idle(HOLDOFF + 1, 50);
        out_ready = 1'b1;
        send(50);
        check("st2.clear", out_valid, 0);
        send(600); send(600); send(50);
        check("st3.valid", out_valid, 1);
        send(50);
        check("st3.clear", out_valid, 0);
        idle(HOLDOFF, 50);
`ifdef FPD_STATS_EN
        check("stats.events", event_count, 2);
        check("stats.drops", drop_count, 1);
`endif

        // Reset mid-pulse with a stalled record pending
        out_ready = 1'b0;
        send(700); send(700); send(50);
        idle(HOLDOFF + 1, 50);
        send(500); send(500);
        reset = 1'b0;
        idle(2, 50);
        check("rst2.valid", out_valid, 0);
        check("rst2.amp", peak_amp, 0);
        check("rst2.time", peak_time, 0);
        check("rst2.width", peak_width, 0);
`ifdef FPD_STATS_EN
        check("rst2.events", event_count, 0);
        check("rst2.drops", drop_count, 0);
`endif
        reset = 1'b1;
        ts = 0;
        send(50);
        check("rst2.no_event", out_valid, 0);
        out_ready = 1'b1;
        send(500); send(500); send(50);
        check_record("post_rst", 500, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
